// File: rtl/add_job_sched_pkg.sv
// Shared types for the add-by-increment job scheduler.
// Holds the FSM state encoding and the default operand width.
package add_job_sched_pkg;

   localparam int DEF_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/add_job_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a last-grant pointer.
// Ports: clk_i, rst_ni (async, active-low), req_i[1:0], advance_i, gnt_o[1:0] one-hot.
module rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] gnt_o
);

   // Index granted most recently; 1 after reset so index 0 wins the first tie.
   logic last_q;

   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else if (advance_i && (gnt_o != 2'b00)) begin
         last_q <= gnt_o[1];
      end
   end

endmodule

// File: rtl/add_job_sched.sv
// Two-requester job scheduler: adds a+b by loading a and incrementing b times.
// Ports: clk, rst (async low), req_valid/req_ready + operands, res_valid/res_ready, res, res_id, cnt, busy.
module add_job_sched
   import add_job_sched_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   input  logic [W-1:0] req_a0,
   input  logic [W-1:0] req_b0,
   input  logic [W-1:0] req_a1,
   input  logic [W-1:0] req_b1,
   output logic [1:0]   req_ready,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W:0]   res,
   output logic         res_id,
   output logic [W:0]   cnt,
   output logic         busy
);

   localparam logic [W:0] ONE = (W+1)'(1);

   state_e       state_q, state_d;
   logic [W:0]   res_q, res_d;
   logic [W:0]   cnt_q, cnt_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic         id_q, id_d;
   logic [1:0]   gnt;
   logic         adv;
   logic [W-1:0] sel_a, sel_b;

   rr_arb2 u_arb (
      .clk_i     (clk),
      .rst_ni    (rst),
      .req_i     (req_valid),
      .advance_i (adv),
      .gnt_o     (gnt)
   );

   assign sel_a = gnt[1] ? req_a1 : req_a0;
   assign sel_b = gnt[1] ? req_b1 : req_b0;

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      adv     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid != 2'b00) begin
               adv     = 1'b1;
               res_d   = {1'b0, sel_a};
               cnt_d   = {1'b0, sel_b};
               a_d     = sel_a;
               b_d     = sel_b;
               id_d    = gnt[1];
               state_d = COUNT;
            end
         end
         COUNT: begin
            // cnt reaching zero costs one extra cycle before DONE.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - ONE;
               res_d = res_q + ONE;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         res_q   <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
      end
   end

   // Grant is only offered in IDLE and is forced low while reset is held.
   assign req_ready = (state_q == IDLE && rst) ? gnt : 2'b00;
   assign res_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign res       = res_q;
   assign cnt       = cnt_q;
   assign res_id    = id_q;

endmodule
